// File: rtl/dispatch_serializer.sv
// Dispatch serializer: tracks in-flight instructions and runs privileged,
// CSR and TLB instructions alone with drain, commit wait and refill bubble.
module dispatch_serializer #(
  parameter int MAX_INFLIGHT   = 15,
  parameter int REFILL_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pri_req_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [1:0]    issue_cnt_i,
  input  logic [1:0]    commit_cnt_i,
  input  logic          commit_pri_i,
  output logic          block_o,
  output logic          single_o,
  output logic          pri_grant_o,
  output logic [CW-1:0] inflight_o,
  output logic          busy_o,
  output logic          timeout_o,
  output logic          err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (REFILL_CYCLES > 0) ? $clog2(REFILL_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, DRAIN, ISSUE, WAIT_COMMIT, REFILL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [RW-1:0] refill_q, refill_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;

  logic [CW:0]   sum, cmt, diff;
  logic          watched, expire;

  always_comb begin
    sum     = {1'b0, inflight_q} + (stall_i ? '0 : (CW+1)'(issue_cnt_i));
    cmt     = (CW+1)'(commit_cnt_i);
    diff    = sum - cmt;
    watched = (state_q == DRAIN) || (state_q == WAIT_COMMIT);
    expire  = watched && (wdog_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    refill_d   = refill_q;
    wdog_d     = '0;
    err_d      = err_q;
    if (flush_i) begin
      state_d    = IDLE;
      inflight_d = '0;
      refill_d   = '0;
    end else if (expire) begin
      state_d    = IDLE;
      inflight_d = '0;
    end else begin
      if (cmt > sum) begin
        inflight_d = '0;
        err_d      = 1'b1;
      end else if (diff > (CW+1)'(MAX_INFLIGHT)) begin
        inflight_d = CW'(MAX_INFLIGHT);
        err_d      = 1'b1;
      end else begin
        inflight_d = diff[CW-1:0];
      end
      unique case (state_q)
        IDLE: begin
          if (pri_req_i) state_d = DRAIN;
        end
        DRAIN: begin
          wdog_d = wdog_q + TW'(1);
          if (inflight_q == '0 && !stall_i) state_d = ISSUE;
        end
        ISSUE: begin
          if (!stall_i && issue_cnt_i != 2'd0) begin
            state_d = WAIT_COMMIT;
            if (issue_cnt_i == 2'd2) err_d = 1'b1;
          end
        end
        WAIT_COMMIT: begin
          wdog_d = wdog_q + TW'(1);
          if (commit_pri_i) begin
            state_d  = (REFILL_CYCLES == 0) ? IDLE : REFILL;
            refill_d = RW'(REFILL_CYCLES);
          end
        end
        REFILL: begin
          refill_d = refill_q - RW'(1);
          if (refill_q == RW'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      // leaving a watched state restarts the watchdog on the next entry
      if (state_d != state_q) wdog_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      refill_q   <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      refill_q   <= refill_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
    end
  end

  assign block_o     = (state_q == DRAIN) || (state_q == WAIT_COMMIT) ||
                       (state_q == REFILL) ||
                       ((state_q == IDLE) && pri_req_i && !flush_i);
  assign pri_grant_o = (state_q == ISSUE) && !flush_i;
  assign single_o    = pri_grant_o;
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = expire && !flush_i;
  assign inflight_o  = inflight_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dispatch_serializer.sv
// Bench for dispatch_serializer: phase-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_dispatch_serializer;

  localparam int MAXI = 15;
  localparam int RC   = 2;
  localparam int TO   = 1023;
  localparam int P_IDLE = 0, P_DRAIN = 1, P_ISSUE = 2, P_WAIT = 3, P_REF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pri_req_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [1:0] issue_cnt_i = 2'd0, commit_cnt_i = 2'd0;
  logic       commit_pri_i = 1'b0;
  logic       block_o, single_o, pri_grant_o, busy_o, timeout_o, err_o;
  logic [3:0] inflight_o;

  int errors = 0;
  int checks = 0;

  int m_ph = 0, m_inf = 0, m_ref = 0, m_wd = 0, m_err = 0;

  dispatch_serializer dut (
    .clk(clk), .rst_n(rst_n),
    .pri_req_i(pri_req_i), .stall_i(stall_i), .flush_i(flush_i),
    .issue_cnt_i(issue_cnt_i), .commit_cnt_i(commit_cnt_i),
    .commit_pri_i(commit_pri_i),
    .block_o(block_o), .single_o(single_o), .pri_grant_o(pri_grant_o),
    .inflight_o(inflight_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int wd_hit();
    return ((m_ph == P_DRAIN || m_ph == P_WAIT) && !flush_i &&
            m_wd + 1 == TO) ? 1 : 0;
  endfunction

  task automatic model_step();
    int iss, v, nph;
    iss = stall_i ? 0 : int'(issue_cnt_i);
    if (flush_i) begin
      m_ph = P_IDLE; m_inf = 0; m_ref = 0; m_wd = 0;
    end else if (wd_hit() != 0) begin
      m_ph = P_IDLE; m_inf = 0; m_wd = 0;
    end else begin
      v = m_inf + iss - int'(commit_cnt_i);
      if (v < 0) begin v = 0; m_err = 1; end
      else if (v > MAXI) begin v = MAXI; m_err = 1; end
      nph = m_ph;
      case (m_ph)
        P_IDLE:  if (pri_req_i) nph = P_DRAIN;
        P_DRAIN: if (m_inf == 0 && !stall_i) nph = P_ISSUE;
        P_ISSUE: if (!stall_i && issue_cnt_i != 0) begin
          nph = P_WAIT;
          if (issue_cnt_i == 2) m_err = 1;
        end
        P_WAIT:  if (commit_pri_i) begin
          if (RC == 0) nph = P_IDLE;
          else begin nph = P_REF; m_ref = RC; end
        end
        default: begin
          if (m_ref == 1) nph = P_IDLE;
          m_ref = m_ref - 1;
        end
      endcase
      if (nph == m_ph && (m_ph == P_DRAIN || m_ph == P_WAIT)) m_wd++;
      else m_wd = 0;
      m_ph = nph;
      m_inf = v;
    end
  endtask

  // every-cycle comparison against the model, then advance the model
  initial begin
    int eb, eg;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ph = P_IDLE; m_inf = 0; m_ref = 0; m_wd = 0; m_err = 0;
      end
      eb = (m_ph == P_DRAIN || m_ph == P_WAIT || m_ph == P_REF ||
            (m_ph == P_IDLE && pri_req_i && !flush_i)) ? 1 : 0;
      eg = (m_ph == P_ISSUE && !flush_i) ? 1 : 0;
      chk("m_block", 32'(block_o), 32'(eb));
      chk("m_grant", 32'(pri_grant_o), 32'(eg));
      chk("m_single", 32'(single_o), 32'(eg));
      chk("m_inflight", 32'(inflight_o), 32'(m_inf));
      chk("m_busy", 32'(busy_o), 32'(m_ph != P_IDLE));
      chk("m_timeout", 32'(timeout_o), 32'(rst_n ? wd_hit() : 0));
      chk("m_err", 32'(err_o), 32'(m_err));
      if (rst_n) model_step();
    end
  end

  task automatic step(input logic pri, input logic stl, input logic fl,
                      input logic [1:0] iss, input logic [1:0] cm,
                      input logic cp);
    @(posedge clk); #1;
    pri_req_i = pri; stall_i = stl; flush_i = fl;
    issue_cnt_i = iss; commit_cnt_i = cm; commit_pri_i = cp;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    int pend;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_block", 32'(block_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_inflight", 32'(inflight_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // counter fill and drain
    repeat (4) step(0, 0, 0, 2, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("fill8", 32'(inflight_o), 8);
    repeat (7) step(0, 0, 0, 0, 1, 0);
    idle();
    chk("drain0", 32'(inflight_o), 0);
    chk("drain_err", 32'(err_o), 0);

    // full serialized sequence with three in flight
    step(0, 0, 0, 2, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("c0_block", 32'(block_o), 1);
    chk("c0_inflight", 32'(inflight_o), 3);
    repeat (3) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("c4_grant", 32'(pri_grant_o), 0);
    step(1, 0, 0, 1, 0, 0);
    chk("c5_grant", 32'(pri_grant_o), 1);
    chk("c5_single", 32'(single_o), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("c6_block", 32'(block_o), 1);
    chk("c6_grant", 32'(pri_grant_o), 0);
    idle();
    step(0, 0, 0, 0, 1, 1);
    idle();
    chk("c9_block", 32'(block_o), 1);
    idle();
    chk("c10_block", 32'(block_o), 1);
    idle();
    chk("c11_block", 32'(block_o), 0);
    chk("c11_busy", 32'(busy_o), 0);

    // flush while waiting for commit
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 2, 0, 0);
    step(0, 0, 0, 2, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("fl_inflight", 32'(inflight_o), 5);
    idle();
    chk("fl_busy", 32'(busy_o), 0);
    chk("fl_inflight0", 32'(inflight_o), 0);
    chk("fl_block", 32'(block_o), 0);

    // stalled issue holds the grant
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (3) begin
      step(1, 1, 0, 1, 0, 0);
      chk("st_grant", 32'(pri_grant_o), 1);
      chk("st_inflight", 32'(inflight_o), 0);
    end
    step(1, 0, 0, 1, 0, 0);
    chk("st_grant_go", 32'(pri_grant_o), 1);
    idle();
    chk("st_wait_block", 32'(block_o), 1);
    chk("st_wait_grant", 32'(pri_grant_o), 0);
    chk("st_wait_infl", 32'(inflight_o), 1);
    step(0, 0, 0, 0, 1, 1);
    repeat (3) idle();
    chk("st_done", 32'(busy_o), 0);

    // watchdog in DRAIN
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    k = 0;
    while (k <= TO + 50) begin
      k++;
      step(1, 0, 0, 0, 0, 0);
      if (timeout_o) break;
    end
    chk("to_cycles", 32'(k), TO);
    idle();
    chk("to_busy", 32'(busy_o), 0);
    chk("to_inflight", 32'(inflight_o), 0);
    chk("to_pulse_off", 32'(timeout_o), 0);

    // underflow is sticky; async reset clears it at once
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 2, 0);
    idle();
    chk("uf_inflight", 32'(inflight_o), 0);
    chk("uf_err", 32'(err_o), 1);
    repeat (3) idle();
    chk("uf_sticky", 32'(err_o), 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("ar_busy_pre", 32'(busy_o), 1);
    pri_req_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy_o), 0);
    chk("ar_block", 32'(block_o), 0);
    chk("ar_err", 32'(err_o), 0);
    chk("ar_inflight", 32'(inflight_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // random traffic against the model
    pend = 0;
    for (int n = 0; n < 3000; n++) begin
      int blk, gr, iv, cv;
      @(posedge clk); #1;
      flush_i = ($urandom_range(0, 59) == 0);
      stall_i = ($urandom_range(0, 3) == 0);
      if (m_ph == P_IDLE && pend == 0 && $urandom_range(0, 5) == 0) pend = 1;
      pri_req_i = (pend != 0);
      blk = (m_ph != P_IDLE && m_ph != P_ISSUE) ||
            (m_ph == P_IDLE && pri_req_i && !flush_i);
      gr = (m_ph == P_ISSUE && !flush_i);
      if (gr) iv = ($urandom_range(0, 49) == 0) ? 2 : 1;
      else if (blk || m_inf > MAXI - 2) iv = 0;
      else iv = $urandom_range(0, 2);
      cv = $urandom_range(0, (m_inf < 2) ? m_inf : 2);
      if ($urandom_range(0, 299) == 0) cv = 2;
      issue_cnt_i = 2'(iv);
      commit_cnt_i = 2'(cv);
      commit_pri_i = (m_ph == P_WAIT) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 29) == 0);
      if (gr && !stall_i && iv != 0) pend = 0;
      if (flush_i) pend = 0;
    end
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
